// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned NREQ             = 8;
  localparam int unsigned IDX_W            = 3;
  localparam int unsigned MAX_HOLD_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb_8_grant_dec.sv
// Enabled 3-to-8 one-hot decoder; all outputs low while the enable is low.
module grant_dec
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] gnt_idx,
  input  logic             gnt_vld,
  output logic [NREQ-1:0]  gnt
);

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb_8.sv
// Eight-way round-robin arbiter with registered grant index and decoded grant lines.
// Optional forced-release timeout and lockout enabled by defining ARB_TIMEOUT_EN.
module rr_arb_8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             tmo
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("rr_arb_8: MAX_HOLD must be in 1..255");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  lock_vec;
  logic [IDX_W:0]   pick;
  logic             expire;

  // Rotate so ptr+1 sits at bit 0, take the lowest set bit, then rotate back.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] vec,
                                             input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0]  base;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              found;
    logic [IDX_W-1:0]  off;
    base  = last + 1'b1;
    dbl   = {vec, vec} >> base;
    rot   = dbl[NREQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i[IDX_W-1:0];
      end
    end
    return {found, base + off};
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    elig    = req & ~lock_vec;
    pick    = rr_pick(elig, ptr_q);
    case (state_q)
      IDLE: begin
        if (pick[IDX_W]) begin
          state_d = GRANT;
          idx_d   = pick[IDX_W-1:0];
          ptr_d   = pick[IDX_W-1:0];
        end
      end
      GRANT: begin
        if (!req[idx_q] || expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] lock_q, lock_d;
  logic [NREQ-1:0] lock_set;
  logic            tmo_q, tmo_d;

  // Expiry only counts as forced when the owner is still requesting.
  assign expire   = (state_q == GRANT) && (cnt_q == HOLD_LAST) && req[idx_q];
  assign lock_vec = lock_q;

  always_comb begin
    cnt_d    = (state_q == GRANT && state_d == GRANT) ? cnt_q + 8'd1 : 8'd0;
    lock_set = '0;
    if (expire) lock_set[idx_q] = 1'b1;
    lock_d   = (lock_q & req) | lock_set;
    tmo_d    = expire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lock_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  assign expire   = 1'b0;
  assign lock_vec = '0;
  assign tmo      = 1'b0;
`endif

  assign gnt_vld = (state_q == GRANT);
  assign gnt_idx = idx_q;

  grant_dec u_grant_dec (
    .gnt_idx (idx_q),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

endmodule

// File: tb/tb_rr_arb_8.sv
// Scoreboard bench for rr_arb_8: stimulus queues hand-computed per-cycle expectations,
// a monitor compares them after each rising edge. Timeout cases need ARB_TIMEOUT_EN.
module tb_rr_arb_8;

  typedef struct {
    logic [7:0] gnt;
    logic       tmo;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  rr_arb_8 #(.MAX_HOLD(4)) dut (
`else
  rr_arb_8 dut (
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i[2:0];
    return r;
  endfunction

  task automatic step(input logic [7:0] r, input logic [7:0] eg, input logic et,
                      input string tag);
    exp_t e;
    @(negedge clk);
    req   = r;
    e.gnt = eg;
    e.tmo = et;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare the oldest expectation once outputs settle after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
        chk({e.tag, ".vld"}, 32'(gnt_vld), 32'(|e.gnt));
        chk({e.tag, ".tmo"}, 32'(tmo), 32'(e.tmo));
        chk({e.tag, ".onehot"}, 32'($onehot0(gnt)), 32'd1);
        if (|e.gnt) chk({e.tag, ".idx"}, 32'(gnt_idx), 32'(enc(e.gnt)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oh;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.vld", 32'(gnt_vld), 32'h0);
    chk("rst.idx", 32'(gnt_idx), 32'h0);
    chk("rst.tmo", 32'(tmo), 32'h0);
    repeat (5) step(8'h00, 8'h00, 1'b0, "idle");

    // All requesting; each owner drops for one edge after three granted cycles.
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      repeat (3) step(8'hFF, oh, 1'b0, "rr_hold");
      step(8'hFF & ~oh, 8'h00, 1'b0, "rr_dead");
    end
    step(8'hFF, 8'h01, 1'b0, "rr_wrap");
    step(8'h00, 8'h00, 1'b0, "rr_rel");

    // ptr now 0: lone req 7, then 0 wins over 7 once ptr sits at 7.
    step(8'h80, 8'h80, 1'b0, "ptr7");
    step(8'h00, 8'h00, 1'b0, "ptr7_rel");
    step(8'h81, 8'h01, 1'b0, "ptr_wrap0");
    step(8'h81, 8'h01, 1'b0, "ptr_wrap0_hold");
    step(8'h80, 8'h00, 1'b0, "ptr_dead");
    step(8'h80, 8'h80, 1'b0, "ptr_then7");
    step(8'h00, 8'h00, 1'b0, "ptr_rel");

    // No preemption: req 5 waits behind the holder 3.
    step(8'h08, 8'h08, 1'b0, "hold3");
    step(8'h08, 8'h08, 1'b0, "hold3");
    step(8'h28, 8'h08, 1'b0, "nopreempt");
    step(8'h28, 8'h08, 1'b0, "nopreempt");
    step(8'h20, 8'h00, 1'b0, "hold_dead");
    step(8'h20, 8'h20, 1'b0, "then5");
    step(8'h00, 8'h00, 1'b0, "then5_rel");

    // Async reset while idx 4 holds (ptr 5 -> search starts at 6, only 4 set).
    step(8'h10, 8'h10, 1'b0, "pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.gnt", 32'(gnt), 32'h0);
    chk("async_rst.vld", 32'(gnt_vld), 32'h0);
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h03, 8'h01, 1'b0, "post_rst_ptr");
    step(8'h00, 8'h00, 1'b0, "post_rst_rel");

`ifdef ARB_TIMEOUT_EN
    do_reset();
    repeat (4) step(8'h05, 8'h01, 1'b0, "to_hold0");
    step(8'h05, 8'h00, 1'b1, "to_force");
    step(8'h05, 8'h04, 1'b0, "to_grant2");
    step(8'h05, 8'h04, 1'b0, "to_hold2");
    step(8'h05, 8'h04, 1'b0, "to_hold2");
    step(8'h01, 8'h00, 1'b0, "to_rel2");
    step(8'h01, 8'h00, 1'b0, "to_locked0");
    step(8'h01, 8'h00, 1'b0, "to_locked0");
    step(8'h00, 8'h00, 1'b0, "to_unlock");
    step(8'h01, 8'h01, 1'b0, "to_regrant0");
    repeat (3) step(8'h01, 8'h01, 1'b0, "to_hold0b");
    step(8'h00, 8'h00, 1'b0, "to_vol_expiry");
    step(8'h01, 8'h01, 1'b0, "to_no_lock");
    step(8'h00, 8'h00, 1'b0, "to_end");
`endif

    repeat (3) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
